// File: rtl/irq_sched_block.sv
// irq_sched_block: edge-latched, masked interrupt scheduler that drains the MIPS pipeline,
// redirects fetch to a per-source vector and returns to the saved PC on eoi. Option macro: IRQ_ROTATE_PRIO_EN.
module irq_sched_block #(
  parameter int          N_SRC        = 4,
  parameter int          IDW          = 2,
  parameter logic [15:0] VEC_BASE     = 16'h0100,
  parameter int          VEC_SHIFT    = 4,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             eoi,
  input  logic [15:0]      current_address,
  output logic             stall_req,
  output logic             pc_mux_sel,
  output logic [15:0]      jmp_loc,
  output logic [15:0]      epc,
  output logic             irq_active,
  output logic [IDW-1:0]   irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask_out
);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_VECTOR, S_SERVICE, S_RETURN} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] eligible, rise, vec_clr;
  logic [15:0]      epc_q, epc_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic [IDW-1:0]   win_id, cand;
  logic [3:0]       cnt_q, cnt_d;
  logic             win_found;

`ifdef IRQ_ROTATE_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;

  // The source after the one just vectored becomes the highest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_VECTOR) ptr_d = IDW'((int'(irq_id_q) + 1) % N_SRC);
  end
`endif

  assign rise     = irq_in & ~irq_prev_q;
  assign eligible = pending_q & mask_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N_SRC; i++) begin
`ifdef IRQ_ROTATE_PRIO_EN
      cand = IDW'((int'(ptr_q) + i) % N_SRC);
`else
      cand = IDW'(i);
`endif
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    irq_id_d   = irq_id_q;
    epc_d      = epc_q;
    vec_clr    = '0;
    stall_req  = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = 16'h0000;
    irq_active = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          irq_id_d = win_id;
          epc_d    = current_address;
          cnt_d    = 4'(DRAIN_CYCLES - 1);
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (cnt_q == 4'd0) state_d = S_VECTOR;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_VECTOR: begin
        stall_req         = 1'b1;
        pc_mux_sel        = 1'b1;
        jmp_loc           = VEC_BASE + (16'(irq_id_q) << VEC_SHIFT);
        vec_clr[irq_id_q] = 1'b1;
        state_d           = S_SERVICE;
      end
      S_SERVICE: begin
        irq_active = 1'b1;
        if (eoi) state_d = S_RETURN;
      end
      S_RETURN: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = epc_q;
        irq_active = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh edge on the source being vectored outranks its clear.
  assign pending_d  = (pending_q & ~vec_clr) | rise;
  assign mask_d     = mask_wr ? mask_data : mask_q;
  assign irq_prev_d = irq_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      epc_q      <= '0;
      irq_id_q   <= '0;
      cnt_q      <= '0;
`ifdef IRQ_ROTATE_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      epc_q      <= epc_d;
      irq_id_q   <= irq_id_d;
      cnt_q      <= cnt_d;
`ifdef IRQ_ROTATE_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign epc      = epc_q;
  assign irq_id   = irq_id_q;
  assign pending  = pending_q;
  assign mask_out = mask_q;

endmodule

// File: doc/irq_sched_block.md
Name: irq_sched_block

Overview:
- Interrupt scheduler for the 5-stage MIPS pipeline.
- Latches edge-triggered requests from N_SRC sources, masks them, arbitrates one winner, freezes fetch while the pipeline drains, then redirects the PC to a per-source vector.
- On end-of-interrupt it redirects the PC back to the saved return address.
- Its redirect outputs are OR-ed with the jump controller's PC mux select and jump location ahead of the PC/IM block.

Parameters:
- N_SRC, 4: number of interrupt sources (2..8).
- IDW, 2: width of source ID; must equal clog2(N_SRC).
- VEC_BASE, 16'h0100: address of the source-0 handler.
- VEC_SHIFT, 4: vector spacing; handler k sits at VEC_BASE + (k << VEC_SHIFT).
- DRAIN_CYCLES, 3: fetch-stall cycles before redirect (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  N_SRC  raw requests; each rising edge is one event.
- mask_wr  in  1  loads mask_data into the mask register.
- mask_data  in  N_SRC  new mask value; bit=1 enables the source.
- eoi  in  1  end-of-interrupt pulse from the return-instruction decode.
- current_address  in  16  PC of the next fetch.
- stall_req  out  1  freezes fetch; OR-ed into the stall path.
- pc_mux_sel  out  1  one-cycle redirect strobe.
- jmp_loc  out  16  redirect target, valid only while pc_mux_sel=1.
- epc  out  16  saved return address.
- irq_active  out  1  a handler is in service.
- irq_id  out  IDW  ID of the source in service.
- pending  out  N_SRC  latched, not-yet-serviced events.
- mask_out  out  N_SRC  current mask.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; pending, mask, epc, irq_id, the drain counter and the edge-detect flops are cleared.
  - stall_req, pc_mux_sel and irq_active read 0; jmp_loc reads 16'h0000.
  - A reset mid-operation abandons any in-flight interrupt with no redirect.
- Edge detect:
  - irq_in is registered once; pending[k] sets when irq_in[k]=1 and its previous sample was 0.
  - pending[k] stays set until that source is vectored.
- Mask:
  - mask_wr takes effect on the next edge and is legal in any state.
  - Masking a source does not clear its pending bit.
  - A mask change after the IDLE decision does not cancel the committed interrupt.
- Eligibility: eligible = pending & mask. The winner is the lowest eligible index under fixed priority.
- IDLE:
  - If eligible != 0, latch the winner into irq_id, capture epc <= current_address, load the counter with DRAIN_CYCLES-1, go to DRAIN.
  - stall_req=1 from the following cycle.
- DRAIN:
  - stall_req=1; the counter decrements each cycle.
  - At counter=0, go to VECTOR.
- VECTOR (exactly 1 cycle):
  - pc_mux_sel=1 and jmp_loc = VEC_BASE + (irq_id << VEC_SHIFT), truncated to 16 bits.
  - pending[irq_id] clears; stall_req=1; next state SERVICE.
  - If a new edge arrives on the same source in this cycle, set wins and pending stays 1.
- SERVICE:
  - irq_active=1, stall_req=0.
  - New edges keep latching into pending; there is no nesting.
  - eoi=1 moves to RETURN.
- RETURN (exactly 1 cycle):
  - pc_mux_sel=1, jmp_loc=epc, irq_active=1; next state IDLE.
  - A still-eligible request is taken at the earliest one cycle later, from IDLE.
- eoi outside SERVICE is ignored.
- Total latency: edge on irq_in to pc_mux_sel is DRAIN_CYCLES+3 clocks (1 sync, 1 IDLE decision, DRAIN_CYCLES drain, VECTOR).

Optional Feature:
- Macro IRQ_ROTATE_PRIO_EN.
- When defined:
  - Priority rotates; after servicing source k, source (k+1) mod N_SRC has highest priority, then ascending with wrap.
  - The rotation pointer resets to 0 and advances in VECTOR.
- When undefined: fixed priority, lowest index wins. No pointer register is built.

Test Plan:
- Reset, then mask_data=4'b1111 and a rising edge on irq_in[2] with current_address=16'h0040:
  - stall_req goes high for 4 cycles (DRAIN_CYCLES+1);
  - pc_mux_sel=1 with jmp_loc=16'h0120 at clock 6 after the edge;
  - epc=16'h0040 and irq_id=2.
- Edges on irq_in[1] and irq_in[3] in the same cycle with all enabled:
  - source 1 is vectored (jmp_loc=16'h0110) first;
  - after eoi, RETURN gives jmp_loc=epc;
  - source 3 is then vectored (16'h0130) with pending=4'b0000 afterwards.
- Mask=4'b0000, edge on irq_in[0]:
  - pending=4'b0001, no stall or redirect for 20 cycles;
  - writing mask=4'b0001 triggers the vector to 16'h0100.
- During SERVICE of source 0, an edge on irq_in[0]:
  - pending[0]=1 is held with no redirect;
  - eoi gives a one-cycle RETURN, then a re-vector to 16'h0100.
- Assert reset during DRAIN:
  - all outputs return to reset values asynchronously;
  - no pc_mux_sel pulse occurs;
  - pending=0 after reset release.
- With IRQ_ROTATE_PRIO_EN, sources 0 and 1 pending after servicing source 0:
  - source 1 is served before a re-raised source 0.
